traffic_phase_fsm: RTL and testbench
====================================

# traffic_phase_fsm

Phase sequencer for a two-road intersection (main road / side road) with a pedestrian crossing on the main road. It sits directly downstream of the clock-divider stage and consumes that stage's single-cycle `tick` pulse as its time base. It counts ticks per phase, advances through a fixed six-phase cycle gated by road and pedestrian requests, and drives registered lamp outputs.

## Interface
- `T_MG`, 6: minimum main-green duration, in ticks.
- `T_Y`, 3: yellow duration (both roads), in ticks.
- `T_AR`, 1: all-red clearance duration, in ticks.
- `T_SG`, 4: side-green duration, in ticks.
- `CW`, 4: phase tick counter width. All `T_*` values must satisfy 1 ≤ T ≤ 2^CW−1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  time-base pulse from the divider. Sampled each `clk`; each high cycle counts as one tick.
- `side_req`  in  1  side-road vehicle sensor, level.
- `ped_req`  in  1  pedestrian button, pulse; latched internally.
- `main_rgy`  out  3  main-road lamps, bit order {red, yellow, green}, one-hot.
- `side_rgy`  out  3  side-road lamps, same encoding.
- `ped_walk`  out  1  walk lamp for crossing the main road.
- `phase`  out  3  current phase code, for debug and observation.

## Operation
- Phases and codes:
  - MG = 0 (main green)
  - MY = 1 (main yellow)
  - ARA = 2 (all red, A)
  - SG = 3 (side green)
  - SY = 4 (side yellow)
  - ARB = 5 (all red, B)
- Fixed cycle: MG → MY → ARA → SG → SY → ARB → MG.
- Lamp decode:
  - MG: main = 001, side = 100.
  - MY: main = 010, side = 100.
  - ARA, ARB: main = 100, side = 100.
  - SG: main = 100, side = 001.
  - SY: main = 100, side = 010.
- Tick counter `cnt`:
  - Increments on each `tick` within a phase.
  - Clears to 0 on every phase change.
- Exit condition for all phases except MG: `tick` is high and `cnt` equals T_phase−1. MY and SY use `T_Y`; ARA and ARB use `T_AR`; SG uses `T_SG`.
- MG exit condition: `tick` is high, `cnt` ≥ `T_MG`−1, and `req` is true, where `req` = `side_req` | `ped_pend` | `ped_req`.
- MG hold: if the minimum green has elapsed but there is no request, MG holds and `cnt` saturates at `T_MG`−1. A late request then exits on its first tick.
- Pedestrian latch `ped_pend`:
  - Set by `ped_req` in any phase.
  - On the SG entry edge, `walk_en` is loaded with `ped_pend` | `ped_req` and `ped_pend` is cleared in the same edge.
  - A `ped_req` pulse arriving during SG–ARB sets `ped_pend` for the next cycle.
- `ped_walk` = 1 only while in SG with `walk_en` set. `walk_en` clears on exit from SG.
- Safety rules:
  - The main and side lamp outputs must never both be non-red.
  - An illegal `phase` value (6, 7) forces ARB on the next edge, with `cnt` = 0.
- Reset values: phase = MG, `cnt` = 0, `ped_pend` = 0, `walk_en` = 0, `main_rgy` = 001, `side_rgy` = 100, `ped_walk` = 0.

## Timing
- Every output is a flop, updated on the same `clk` edge as the phase register. There is no combinational path from any input to any output.
- Latency: the edge that samples the terminal `tick` is the edge on which the new phase and new lamps appear.
- `tick` held high for k cycles counts as k ticks. No edge detection is performed; the upstream stage guarantees single-cycle pulses.
- Cycle length with continuous requests: `T_MG` + 2·`T_Y` + 2·`T_AR` + `T_SG` ticks. With defaults this is 18 ticks.
- `side_req` and `ped_req` are used only when `tick` is high, except that `ped_req` is latched on every cycle.
- `rst` asserted mid-phase forces the reset values immediately, without waiting for a clock edge. The first tick after release counts as `cnt` = 0 → 1 in MG.
- Simultaneous events: `ped_req` on the same edge as SG entry is consumed by the walk (walk for this cycle), not left pending.

## Structure
- Shared package `traffic_pkg` holds:
  - Phase codes (MG … ARB).
  - Lamp encodings: RED = 100, YEL = 010, GRN = 001.
  - The phase width constant.
- One sub-module, `phase_timer`:
  - Holds the CW-bit counter, with inputs `tick`, `clr`, `limit`, and `sat`.
  - Output `done` = `tick` & (`cnt` == `limit`−1).
  - When `sat` is high, the counter stops at `limit`−1.
- The FSM, pedestrian latch and lamp registers stay in the top module.

## Test plan
- Reset with defaults → `phase` = 0, `main_rgy` = 001, `side_rgy` = 100, `ped_walk` = 0. Assert `rst` again mid-SG → the same values appear immediately, without a clock edge.
- `side_req` = 0, `ped_req` = 0, 20 ticks → `phase` stays 0 throughout.
- `side_req` = 1 from release → MY after tick 6, ARA after tick 9, SG after tick 10, SY after tick 14, ARB after tick 17, MG after tick 18. Check after every tick that the two roads are never both non-red.
- `side_req` rises after tick 10 → MY on the next tick (tick 11); the minimum green has already been satisfied.
- One `ped_req` pulse at tick 2, `side_req` = 0 → MY after tick 6. `ped_walk` = 1 for exactly the 4 SG ticks, then the sequence returns to MG and holds there, with no second cycle.
- `tick` held high for 3 consecutive cycles in MY → MY counts 3 ticks and the FSM enters ARA on the third cycle.
- Force `phase` = 7 → ARB on the next edge with all lamps red, then MG after `T_AR` ticks.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase sequencer.
// Contents: phase codes, lamp encodings {red, yellow, green}, phase width,
// and lamp decode helpers used by traffic_phase_fsm.
package traffic_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_MG  = 3'd0,
        PH_MY  = 3'd1,
        PH_ARA = 3'd2,
        PH_SG  = 3'd3,
        PH_SY  = 3'd4,
        PH_ARB = 3'd5
    } phase_e;

    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

    // Main-road lamps for a phase; anything not main-green/yellow is red.
    function automatic logic [LAMP_W-1:0] main_lamp(input logic [PHASE_W-1:0] ph);
        case (ph)
            PH_MG:   main_lamp = LAMP_GRN;
            PH_MY:   main_lamp = LAMP_YEL;
            default: main_lamp = LAMP_RED;
        endcase
    endfunction

    // Side-road lamps for a phase; anything not side-green/yellow is red.
    function automatic logic [LAMP_W-1:0] side_lamp(input logic [PHASE_W-1:0] ph);
        case (ph)
            PH_SG:   side_lamp = LAMP_GRN;
            PH_SY:   side_lamp = LAMP_YEL;
            default: side_lamp = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter.
// Ports: clk, rst (async, active-high); tick (time-base pulse); clr (phase
// change, zero the count); limit (phase duration in ticks); sat (hold at
// limit-1 instead of advancing); done = tick on the terminal count.
module phase_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    input  logic          sat,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == (limit - CW'(1)));
    assign done   = tick & at_end;

    // Count ticks; a saturating phase parks on its terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && !(sat && at_end)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Six-phase sequencer for a main/side intersection with a main-road
// pedestrian crossing, timed by the divider's tick pulse.
// Ports: clk, rst (async, active-high); tick (time base); side_req (level
// sensor); ped_req (button pulse, latched); main_rgy / side_rgy (lamps,
// {red, yellow, green}); ped_walk (walk lamp); phase (current phase code).
// All outputs are flops updated on the phase-register edge.
module traffic_phase_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned T_MG = 6,
    parameter int unsigned T_Y  = 3,
    parameter int unsigned T_AR = 1,
    parameter int unsigned T_SG = 4,
    parameter int unsigned CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               side_req,
    input  logic               ped_req,
    output logic [LAMP_W-1:0]  main_rgy,
    output logic [LAMP_W-1:0]  side_rgy,
    output logic               ped_walk,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic               ped_pend_q, ped_pend_d;
    logic               walk_en_q,  walk_en_d;
    logic [LAMP_W-1:0]  main_rgy_q, main_rgy_d;
    logic [LAMP_W-1:0]  side_rgy_q, side_rgy_d;
    logic               ped_walk_q, ped_walk_d;

    logic [CW-1:0]      timer_limit;
    logic               timer_sat;
    logic               timer_clr;
    logic               timer_done;
    logic               req;

    // Duration of the phase currently being timed.
    always_comb begin
        case (phase_q)
            PH_MG:         timer_limit = CW'(T_MG);
            PH_MY, PH_SY:  timer_limit = CW'(T_Y);
            PH_SG:         timer_limit = CW'(T_SG);
            default:       timer_limit = CW'(T_AR);
        endcase
    end

    // Only main green waits for a request, so only it saturates.
    assign timer_sat = (phase_q == PH_MG);
    assign timer_clr = (phase_d != phase_q);

    phase_timer #(
        .CW (CW)
    ) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clr   (timer_clr),
        .limit (timer_limit),
        .sat   (timer_sat),
        .done  (timer_done)
    );

    // A press on the exiting tick counts even before it reaches the latch.
    assign req = side_req | ped_pend_q | ped_req;

    // Next phase, pedestrian bookkeeping and lamp decode.
    always_comb begin
        phase_d    = phase_q;
        ped_pend_d = ped_pend_q | ped_req;
        walk_en_d  = walk_en_q;

        case (phase_q)
            PH_MG:   if (timer_done && req) phase_d = PH_MY;
            PH_MY:   if (timer_done)        phase_d = PH_ARA;
            PH_ARA:  if (timer_done)        phase_d = PH_SG;
            PH_SG:   if (timer_done)        phase_d = PH_SY;
            PH_SY:   if (timer_done)        phase_d = PH_ARB;
            PH_ARB:  if (timer_done)        phase_d = PH_MG;
            default:                        phase_d = PH_ARB;
        endcase

        // SG entry consumes any pending or same-edge press into this walk.
        if ((phase_d == PH_SG) && (phase_q != PH_SG)) begin
            walk_en_d  = ped_pend_q | ped_req;
            ped_pend_d = 1'b0;
        end else if ((phase_q == PH_SG) && (phase_d != PH_SG)) begin
            walk_en_d  = 1'b0;
        end

        main_rgy_d = main_lamp(phase_d);
        side_rgy_d = side_lamp(phase_d);
        ped_walk_d = (phase_d == PH_SG) & walk_en_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_MG;
            ped_pend_q <= 1'b0;
            walk_en_q  <= 1'b0;
            main_rgy_q <= LAMP_GRN;
            side_rgy_q <= LAMP_RED;
            ped_walk_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            ped_pend_q <= ped_pend_d;
            walk_en_q  <= walk_en_d;
            main_rgy_q <= main_rgy_d;
            side_rgy_q <= side_rgy_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign phase    = phase_q;
    assign main_rgy = main_rgy_q;
    assign side_rgy = side_rgy_q;
    assign ped_walk = ped_walk_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Self-checking bench for traffic_phase_fsm with default timing parameters.
// Vectors {tick, side_req, ped_req, expected phase, expected walk} are queued,
// driven on the falling edge, and compared just after the next rising edge.
module tb_traffic_phase_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_rgy;
    logic [2:0] side_rgy;
    logic       ped_walk;
    logic [2:0] phase;

    traffic_phase_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .side_req (side_req),
        .ped_req  (ped_req),
        .main_rgy (main_rgy),
        .side_rgy (side_rgy),
        .ped_walk (ped_walk),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t;
        logic       s;
        logic       p;
        logic [2:0] ph;
        logic       w;
    } vec_t;

    vec_t vq[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected phase after each tick of one full cycle with requests present.
    int exp_cyc [18] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 3, 3, 3, 3, 4, 4, 4, 5, 0};

    function automatic logic [2:0] exp_main(input logic [2:0] ph);
        case (ph)
            3'd0:    exp_main = 3'b001;
            3'd1:    exp_main = 3'b010;
            default: exp_main = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] ph);
        case (ph)
            3'd3:    exp_side = 3'b001;
            3'd4:    exp_side = 3'b010;
            default: exp_side = 3'b100;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [2:0] ph, input logic w);
        chk({nm, " phase"}, int'(phase), int'(ph));
        chk({nm, " main"}, int'(main_rgy), int'(exp_main(ph)));
        chk({nm, " side"}, int'(side_rgy), int'(exp_side(ph)));
        chk({nm, " walk"}, int'(ped_walk), int'(w));
        chk({nm, " safety"}, int'((main_rgy != 3'b100) && (side_rgy != 3'b100)), 0);
    endtask

    task automatic add(input logic t, input logic s, input logic p,
                       input logic [2:0] ph, input logic w);
        vec_t v;
        v.t = t; v.s = s; v.p = p; v.ph = ph; v.w = w;
        vq.push_back(v);
    endtask

    // One tick cycle followed by one idle cycle that must not advance anything.
    task automatic add_tick(input logic s, input logic p, input logic [2:0] ph, input logic w);
        add(1'b1, s, p, ph, w);
        add(1'b0, s, 1'b0, ph, w);
    endtask

    task automatic run_vecs(input string nm);
        vec_t e;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            tick     = vq[i].t;
            side_req = vq[i].s;
            ped_req  = vq[i].p;
            sb.push_back(vq[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk_outs($sformatf("%s[%0d]", nm, i), e.ph, e.w);
        end
        @(negedge clk);
        tick     = 1'b0;
        side_req = 1'b0;
        ped_req  = 1'b0;
        vq.delete();
    endtask

    task automatic do_reset();
        tick     = 1'b0;
        side_req = 1'b0;
        ped_req  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
    endtask

    initial begin
        logic [2:0] ph;

        // Reset values appear without any clock edge.
        #1 rst = 1'b1;
        #1 chk_outs("reset", 3'd0, 1'b0);
        do_reset();

        // No requests: main green holds through 20 ticks.
        for (int k = 0; k < 20; k++) add_tick(1'b0, 1'b0, 3'd0, 1'b0);
        run_vecs("idle");

        // Continuous side request: full 18-tick cycle.
        do_reset();
        for (int k = 0; k < 18; k++) add_tick(1'b1, 1'b0, 3'(exp_cyc[k]), 1'b0);
        run_vecs("side");

        // Reset asserted mid-SG takes effect immediately.
        do_reset();
        for (int k = 0; k < 10; k++) add_tick(1'b1, 1'b0, 3'(exp_cyc[k]), 1'b0);
        run_vecs("to_sg");
        #2 rst = 1'b1;
        #1 chk_outs("rst_mid_sg", 3'd0, 1'b0);

        // Late side request exits on its first tick after minimum green.
        do_reset();
        for (int k = 1; k <= 11; k++) add_tick(k == 11, 1'b0, (k == 11) ? 3'd1 : 3'd0, 1'b0);
        run_vecs("late");

        // Single ped press at tick 2: one cycle with walk in SG, then MG holds.
        do_reset();
        for (int k = 0; k < 28; k++) begin
            ph = (k < 18) ? 3'(exp_cyc[k]) : 3'd0;
            add_tick(1'b0, k == 1, ph, ph == 3'd3);
        end
        run_vecs("ped");

        // Press on the SG-entry edge walks now and leaves nothing pending.
        do_reset();
        for (int k = 0; k < 26; k++) begin
            ph = (k < 18) ? 3'(exp_cyc[k]) : 3'd0;
            add_tick(k < 10, k == 9, ph, ph == 3'd3);
        end
        run_vecs("ped_sg");

        // Tick held high three cycles in MY counts three ticks.
        do_reset();
        for (int k = 0; k < 6; k++) add_tick(1'b1, 1'b0, 3'(exp_cyc[k]), 1'b0);
        add(1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        run_vecs("hold_tick");

        // Illegal phase recovers through ARB.
        do_reset();
        add_tick(1'b0, 1'b0, 3'd0, 1'b0);
        run_vecs("pre_force");
        force dut.phase_q = 3'd7;
        #1 release dut.phase_q;
        #1 chk("forced phase", int'(phase), 7);
        @(posedge clk);
        #1 chk_outs("illegal", 3'd5, 1'b0);
        add(1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
        add_tick(1'b0, 1'b0, 3'd0, 1'b0);
        run_vecs("arb_exit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
